predictor_update_ctrl: RTL and testbench

Sequencer for the branch predictor's BTB and PHT write ports. Clears all 256 predictor entries after reset or on a pipeline flush request. Buffers resolved-branch updates from the execute stage in a 4-entry FIFO and applies each one as a PHT read-modify-write plus a conditional BTB write. Sits between the execute stage and the predictor memories inside CPUTop; lookup read ports are untouched.

---
 rtl/pred_pkg.sv | 40 ++++
 rtl/upd_fifo.sv | 63 ++++++
 rtl/predictor_update_ctrl.sv | 164 ++++++++++++++++
 tb/tb_predictor_update_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_pkg.sv
// Shared types and helpers for the branch predictor update sequencer.
// Holds default geometry, FSM states, queued-update layout and the 2-bit counter rule.
package pred_pkg;

    localparam int         IDX_W    = 8;
    localparam int         TAG_W    = 32 - IDX_W - 2;
    localparam logic [1:0] PHT_INIT = 2'b01;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WR   = 2'd2
    } state_t;

    // PC and target are word addresses, so only bits [31:2] are queued.
    typedef struct packed {
        logic [29:0] pc_w;
        logic        taken;
        logic [29:0] tgt_w;
    } upd_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

endpackage

// File: rtl/upd_fifo.sv
// Synchronous FIFO of resolved-branch updates; head is visible combinationally.
// Writes land one cycle after push; clear empties it without touching the write pointer.
module upd_fifo
    import pred_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  upd_t push_dat,
    input  logic pop,
    output upd_t head_dat,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    upd_t        mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/predictor_update_ctrl.sv
// Sequences BTB/PHT writes: full-table clear after reset/flush, then queued branch updates.
// Each update is a 2-cycle PHT read-modify-write; upd_ready drops when the queue is full or clearing.
module predictor_update_ctrl #(
    parameter int         IDX_W      = pred_pkg::IDX_W,
    parameter int         TAG_W      = 32 - IDX_W - 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] PHT_INIT   = pred_pkg::PHT_INIT
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             flush_req,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    output logic             busy,
    output logic             pht_re,
    output logic [IDX_W-1:0] pht_ra,
    input  logic [1:0]       pht_rd,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_wa,
    output logic [1:0]       pht_wd,
    output logic             btb_we,
    output logic [IDX_W-1:0] btb_wa,
    output logic             btb_wvalid,
    output logic [TAG_W-1:0] btb_wtag,
    output logic [29:0]      btb_wtarget
);

    localparam logic [IDX_W-1:0] K_LAST = '1;

    pred_pkg::state_t state_q;
    pred_pkg::state_t state_d;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W-1:0] k_d;

    pred_pkg::upd_t   push_dat;
    pred_pkg::upd_t   head_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [IDX_W-1:0] head_idx;
    logic [TAG_W-1:0] head_tag;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{upd_pc[1:0], upd_target[1:0]};

    assign push_dat.pc_w  = upd_pc[31:2];
    assign push_dat.taken = upd_taken;
    assign push_dat.tgt_w = upd_target[31:2];

    assign head_idx = head_dat.pc_w[IDX_W-1:0];
    assign head_tag = head_dat.pc_w[29:IDX_W];

    // Updates offered alongside a flush are dropped rather than queued behind the clear.
    assign upd_ready = !rst && !flush_req && (state_q != pred_pkg::INIT) && !fifo_full;
    assign fifo_push = upd_valid && upd_ready;
    assign busy      = rst || (state_q == pred_pkg::INIT);

    upd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_upd_fifo (
        .sysclk   (sysclk),
        .rst      (rst),
        .clear    (flush_req),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= pred_pkg::INIT;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        fifo_pop = 1'b0;
        case (state_q)
            pred_pkg::INIT: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = pred_pkg::IDLE;
                    k_d     = '0;
                end
            end
            pred_pkg::IDLE: begin
                if (!fifo_empty) state_d = pred_pkg::WR;
            end
            pred_pkg::WR: begin
                fifo_pop = 1'b1;
                state_d  = pred_pkg::IDLE;
            end
            default: begin
                state_d = pred_pkg::INIT;
                k_d     = '0;
            end
        endcase
        if (flush_req) begin
            state_d = pred_pkg::INIT;
            k_d     = '0;
        end
    end

    always_comb begin
        pht_re      = 1'b0;
        pht_ra      = '0;
        pht_we      = 1'b0;
        pht_wa      = '0;
        pht_wd      = '0;
        btb_we      = 1'b0;
        btb_wa      = '0;
        btb_wvalid  = 1'b0;
        btb_wtag    = '0;
        btb_wtarget = '0;
        if (!rst) begin
            case (state_q)
                pred_pkg::INIT: begin
                    pht_we = 1'b1;
                    pht_wa = k_q;
                    pht_wd = PHT_INIT;
                    btb_we = 1'b1;
                    btb_wa = k_q;
                end
                pred_pkg::IDLE: begin
                    if (!fifo_empty) begin
                        pht_re = 1'b1;
                        pht_ra = head_idx;
                    end
                end
                pred_pkg::WR: begin
                    // A flush landing on the write cycle discards the update entirely.
                    if (!flush_req) begin
                        pht_we = 1'b1;
                        pht_wa = head_idx;
                        pht_wd = pred_pkg::sat_update(pht_rd, head_dat.taken);
                        if (head_dat.taken) begin
                            btb_we      = 1'b1;
                            btb_wa      = head_idx;
                            btb_wvalid  = 1'b1;
                            btb_wtag    = head_tag;
                            btb_wtarget = head_dat.tgt_w;
                        end
                    end
                end
                default: begin
                    pht_re = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Directed bench: table of single updates plus sequences for reset, backpressure and flushes.
`timescale 1ns/1ps
module tb_predictor_update_ctrl;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_req = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        busy;
    logic        pht_re;
    logic [7:0]  pht_ra;
    logic [1:0]  pht_rd;
    logic        pht_we;
    logic [7:0]  pht_wa;
    logic [1:0]  pht_wd;
    logic        btb_we;
    logic [7:0]  btb_wa;
    logic        btb_wvalid;
    logic [21:0] btb_wtag;
    logic [29:0] btb_wtarget;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    predictor_update_ctrl dut (
        .sysclk(sysclk), .rst(rst), .flush_req(flush_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .busy(busy),
        .pht_re(pht_re), .pht_ra(pht_ra), .pht_rd(pht_rd),
        .pht_we(pht_we), .pht_wa(pht_wa), .pht_wd(pht_wd),
        .btb_we(btb_we), .btb_wa(btb_wa), .btb_wvalid(btb_wvalid),
        .btb_wtag(btb_wtag), .btb_wtarget(btb_wtarget)
    );

    // PHT model: synchronous write, read data registered one cycle after pht_re.
    logic [1:0] pht_mem [256];
    logic [1:0] pht_rd_q;
    always @(posedge sysclk) begin
        if (pht_we) pht_mem[pht_wa] <= pht_wd;
        if (pht_re) pht_rd_q <= pht_mem[pht_ra];
    end
    assign pht_rd = pht_rd_q;

    typedef struct {
        int         c;
        logic [7:0] wa;
        logic [1:0] wd;
    } wlog_t;
    wlog_t wlog[$];
    always @(negedge sysclk) begin
        if (!rst && !busy && pht_we) wlog.push_back('{cyc, pht_wa, pht_wd});
    end

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic [7:0]  idx;
        logic [1:0]  wd;
        logic [21:0] tag;
        logic [29:0] tw;
    } vec_t;
    vec_t vt [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sweep_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge sysclk);
            if (!(busy && pht_we && btb_we && pht_wa == i[7:0] && btb_wa == i[7:0] &&
                  pht_wd == 2'b01 && !btb_wvalid && btb_wtag == '0 && btb_wtarget == '0 &&
                  !upd_ready && !pht_re)) bad++;
        end
        check({name, "_bad_sweep_cycles"}, bad, 0);
        @(negedge sysclk);
        check({name, "_busy_fall"}, busy, 0);
        check({name, "_ready_after"}, upd_ready, 1);
    endtask

    task automatic offer_stream(input string name, input int n, input logic [31:0] base,
                                output int cycles);
        int  acc;
        logic r;
        acc = 0;
        cycles = 0;
        @(posedge sysclk); #1;
        upd_valid = 1'b1; upd_taken = 1'b1;
        upd_pc = base; upd_target = base + 32'h1000;
        while (acc < n && cycles < 100) begin
            @(negedge sysclk);
            r = upd_ready;
            @(posedge sysclk); #1;
            cycles++;
            if (r) begin
                acc++;
                upd_pc = base + 32'(4 * acc);
                upd_target = base + 32'h1000 + 32'(4 * acc);
            end
            if (acc == n) upd_valid = 1'b0;
        end
        upd_valid = 1'b0;
        check({name, "_accepted"}, acc, n);
    endtask

    initial begin
        int cycles;
        int s;
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int s;
        vt[0]  = '{32'h0000_0404, 1'b1, 32'h0000_1000, 8'h01, 2'b10, 22'h000001, 30'h0000_0400};
        vt[1]  = '{32'h0000_0808, 1'b1, 32'h0000_2000, 8'h02, 2'b10, 22'h000002, 30'h0000_0800};
        vt[2]  = '{32'h0000_0808, 1'b1, 32'h0000_2000, 8'h02, 2'b11, 22'h000002, 30'h0000_0800};
        vt[3]  = '{32'h0000_0808, 1'b1, 32'h0000_2000, 8'h02, 2'b11, 22'h000002, 30'h0000_0800};
        vt[4]  = '{32'h0000_0808, 1'b1, 32'h0000_2000, 8'h02, 2'b11, 22'h000002, 30'h0000_0800};
        vt[5]  = '{32'h0000_0808, 1'b0, 32'h0000_2000, 8'h02, 2'b10, 22'h000002, 30'h0000_0800};
        vt[6]  = '{32'h0000_0808, 1'b0, 32'h0000_2000, 8'h02, 2'b01, 22'h000002, 30'h0000_0800};
        vt[7]  = '{32'h0000_0808, 1'b0, 32'h0000_2000, 8'h02, 2'b00, 22'h000002, 30'h0000_0800};
        vt[8]  = '{32'h0000_0808, 1'b0, 32'h0000_2000, 8'h02, 2'b00, 22'h000002, 30'h0000_0800};
        vt[9]  = '{32'h0000_0808, 1'b0, 32'h0000_2000, 8'h02, 2'b00, 22'h000002, 30'h0000_0800};
        vt[10] = '{32'hABCD_E3FC, 1'b1, 32'h8000_0004, 8'hFF, 2'b10, 22'h2AF378, 30'h2000_0001};
        vt[11] = '{32'h0000_0010, 1'b0, 32'h0000_0044, 8'h04, 2'b00, 22'h000000, 30'h0000_0011};
        vt[12] = '{32'h0000_0404, 1'b0, 32'h0000_1000, 8'h01, 2'b01, 22'h000001, 30'h0000_0400};

        // Reset held for two edges; outputs quiet while it is high.
        rst = 1'b1;
        @(posedge sysclk); #1;
        @(negedge sysclk);
        check("rst_busy", busy, 1);
        check("rst_ready", upd_ready, 0);
        check("rst_pht_we", pht_we, 0);
        check("rst_btb_we", btb_we, 0);
        check("rst_pht_re", pht_re, 0);
        check("rst_pht_wa", pht_wa, 0);
        check("rst_pht_wd", pht_wd, 0);
        @(posedge sysclk); #1;
        rst = 1'b0;
        sweep_check("reset");

        for (int i = 0; i < 13; i++) begin
            @(posedge sysclk); #1;
            upd_valid = 1'b1; upd_pc = vt[i].pc; upd_taken = vt[i].taken; upd_target = vt[i].tgt;
            @(negedge sysclk);
            check($sformatf("v%0d_ready", i), upd_ready, 1);
            @(posedge sysclk); #1;
            upd_valid = 1'b0;
            @(negedge sysclk);
            check($sformatf("v%0d_pht_re", i), pht_re, 1);
            check($sformatf("v%0d_pht_ra", i), pht_ra, vt[i].idx);
            @(negedge sysclk);
            check($sformatf("v%0d_pht_we", i), pht_we, 1);
            check($sformatf("v%0d_pht_wa", i), pht_wa, vt[i].idx);
            check($sformatf("v%0d_pht_wd", i), pht_wd, vt[i].wd);
            check($sformatf("v%0d_btb_we", i), btb_we, vt[i].taken);
            if (vt[i].taken) begin
                check($sformatf("v%0d_btb_wa", i), btb_wa, vt[i].idx);
                check($sformatf("v%0d_btb_wvalid", i), btb_wvalid, 1);
                check($sformatf("v%0d_btb_wtag", i), btb_wtag, vt[i].tag);
                check($sformatf("v%0d_btb_wtarget", i), btb_wtarget, vt[i].tw);
            end
            @(negedge sysclk);
            check($sformatf("v%0d_idle_we", i), pht_we, 0);
        end

        // Backpressure: six taken updates to indices 0x40..0x45 with valid held.
        wlog.delete();
        s = cyc + 1;
        offer_stream("bp", 6, 32'h0000_0100, cycles);
        check("bp_accept_cycles", cycles, 6);
        @(negedge sysclk);
        check("bp_full_ready", upd_ready, 0);
        repeat (12) @(negedge sysclk);
        check("bp_write_count", wlog.size(), 6);
        if (wlog.size() == 6) begin
            check("bp_first_latency", wlog[0].c, s + 2);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("bp_wa%0d", i), wlog[i].wa, 8'h40 + 8'(i));
                check($sformatf("bp_wd%0d", i), wlog[i].wd, 2'b10);
                if (i > 0) check($sformatf("bp_gap%0d", i), wlog[i].c - wlog[i-1].c, 2);
            end
        end

        // Flush on the write of the second of four updates; three stay queued.
        wlog.delete();
        offer_stream("fl", 4, 32'h0000_0200, cycles);
        check("fl_accept_cycles", cycles, 4);
        flush_req = 1'b1;
        @(negedge sysclk);
        check("fl_pht_we", pht_we, 0);
        check("fl_btb_we", btb_we, 0);
        check("fl_ready", upd_ready, 0);
        @(posedge sysclk); #1;
        flush_req = 1'b0;
        sweep_check("fl");
        check("fl_fifo_empty", pht_re, 0);
        repeat (4) @(negedge sysclk);
        check("fl_write_count", wlog.size(), 1);
        if (wlog.size() > 0) check("fl_write_idx", wlog[0].wa, 8'h80);

        // Update offered with flush in IDLE is dropped; second flush at k=100 restarts sweep.
        wlog.delete();
        @(posedge sysclk); #1;
        upd_valid = 1'b1; upd_pc = 32'h0000_0300; upd_taken = 1'b1; flush_req = 1'b1;
        @(negedge sysclk);
        check("drop_ready", upd_ready, 0);
        @(posedge sysclk); #1;
        upd_valid = 1'b0; flush_req = 1'b0;
        repeat (100) @(posedge sysclk);
        #1;
        flush_req = 1'b1;
        @(negedge sysclk);
        check("k100_wa", pht_wa, 100);
        check("k100_busy", busy, 1);
        @(posedge sysclk); #1;
        flush_req = 1'b0;
        sweep_check("k100");
        check("drop_fifo_empty", pht_re, 0);
        repeat (3) @(negedge sysclk);
        check("drop_no_write", wlog.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
